mem_stage: RTL and testbench

//  - MEM stage of the 5-stage MIPS pipeline, between EX/MEM and WB.
//  - Consumes EX/MEM register fields and performs data-memory store/load with load-mode extraction.
//  - Resolves branch taken (PCSrc) back to IF.
//  - Owns the MEM/WB pipeline register that feeds write-back.

---
 rtl/mips_pkg.sv | 16 +
 rtl/data_memory.sv | 35 +++
 rtl/mem_stage.sv | 106 ++++++++++
 tb/tb_mem_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg
//   Shared constants for the MIPS pipeline slice: datapath and register-index
//   widths, plus the load-mode encodings carried down from decode.
package mips_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    LOAD_WORD  = 2'b00,
    LOAD_HALF  = 2'b01,
    LOAD_BYTE  = 2'b10,
    LOAD_BYTEU = 2'b11
  } load_mode_t;

endpackage

// File: rtl/data_memory.sv
// data_memory
//   Word-addressed data RAM: synchronous write, asynchronous read.
//   Contents are not reset.
// Ports
//   clk    in   rising-edge clock
//   we     in   write enable (full-word store)
//   addr   in   word index
//   wdata  in   store data
//   rdata  out  combinational read of the addressed word (pre-write value)
module data_memory
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_WORDS];

  // Read is taken from the array before the clock edge updates it, which
  // gives read-before-write for a same-cycle load/store to one word.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage
//   MEM stage of the 5-stage MIPS pipeline. Performs word stores and
//   mode-extracted loads against the data memory, resolves branch-taken
//   back to IF, and holds the MEM/WB pipeline register.
// Ports
//   clk, rst_n                    clock, async active-low reset
//   MEM_*                         EX/MEM register fields
//   IF_pc_src                     branch taken (combinational)
//   WB_reg_write, WB_mem_to_reg   registered control
//   WB_write_back_destination     registered destination register
//   WB_read_data                  registered extracted load data
//   WB_address                    registered ALU result
module mem_stage
  import mips_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  MEM_reg_write,
  input  logic                  MEM_mem_write,
  input  logic                  MEM_mem_read,
  input  logic                  MEM_mem_to_reg,
  input  logic                  MEM_branch,
  input  logic                  MEM_zero,
  input  logic [DATA_W-1:0]     MEM_address,
  input  logic [DATA_W-1:0]     MEM_write_data,
  input  logic [REG_ADDR_W-1:0] MEM_write_back_destination,
  input  logic [1:0]            MEM_load_mode,
  output logic                  IF_pc_src,
  output logic                  WB_reg_write,
  output logic                  WB_mem_to_reg,
  output logic [REG_ADDR_W-1:0] WB_write_back_destination,
  output logic [DATA_W-1:0]     WB_read_data,
  output logic [DATA_W-1:0]     WB_address
);

  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [IDX_W-1:0]  word_idx;
  logic [DATA_W-1:0] word_rd;
  logic [DATA_W-1:0] load_data;
  logic [15:0]       half_sel;
  logic [7:0]        byte_sel;
  logic              store_en;

  assign IF_pc_src = rst_n & MEM_branch & MEM_zero;

  // Upper address bits are dropped, so addresses wrap modulo the RAM size.
  assign word_idx = MEM_address[IDX_W+1:2];

  // A store presented while reset is asserted is discarded.
  assign store_en = MEM_mem_write & rst_n;

  data_memory #(.MEM_WORDS(MEM_WORDS)) u_dmem (
    .clk   (clk),
    .we    (store_en),
    .addr  (word_idx),
    .wdata (MEM_write_data),
    .rdata (word_rd)
  );

  // Little-endian lane selection.
  assign half_sel = MEM_address[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    byte_sel = word_rd[7:0];
    case (MEM_address[1:0])
      2'd0: byte_sel = word_rd[7:0];
      2'd1: byte_sel = word_rd[15:8];
      2'd2: byte_sel = word_rd[23:16];
      2'd3: byte_sel = word_rd[31:24];
      default: byte_sel = word_rd[7:0];
    endcase
  end

  always_comb begin
    load_data = '0;
    if (MEM_mem_read) begin
      case (load_mode_t'(MEM_load_mode))
        LOAD_WORD:  load_data = word_rd;
        LOAD_HALF:  load_data = {{(DATA_W-16){half_sel[15]}}, half_sel};
        LOAD_BYTE:  load_data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        LOAD_BYTEU: load_data = {{(DATA_W-8){1'b0}}, byte_sel};
        default:    load_data = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WB_reg_write              <= 1'b0;
      WB_mem_to_reg             <= 1'b0;
      WB_write_back_destination <= '0;
      WB_read_data              <= '0;
      WB_address                <= '0;
    end else begin
      WB_reg_write              <= MEM_reg_write;
      WB_mem_to_reg             <= MEM_mem_to_reg;
      WB_write_back_destination <= MEM_write_back_destination;
      WB_read_data              <= load_data;
      WB_address                <= MEM_address;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;
  import mips_pkg::*;

  localparam int MEM_WORDS = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MEM_reg_write, MEM_mem_write, MEM_mem_read, MEM_mem_to_reg;
  logic        MEM_branch, MEM_zero;
  logic [31:0] MEM_address, MEM_write_data;
  logic [4:0]  MEM_write_back_destination;
  logic [1:0]  MEM_load_mode;
  logic        IF_pc_src, WB_reg_write, WB_mem_to_reg;
  logic [4:0]  WB_write_back_destination;
  logic [31:0] WB_read_data, WB_address;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_stage #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk                        (clk),
    .rst_n                      (rst_n),
    .MEM_reg_write              (MEM_reg_write),
    .MEM_mem_write              (MEM_mem_write),
    .MEM_mem_read               (MEM_mem_read),
    .MEM_mem_to_reg             (MEM_mem_to_reg),
    .MEM_branch                 (MEM_branch),
    .MEM_zero                   (MEM_zero),
    .MEM_address                (MEM_address),
    .MEM_write_data             (MEM_write_data),
    .MEM_write_back_destination (MEM_write_back_destination),
    .MEM_load_mode              (MEM_load_mode),
    .IF_pc_src                  (IF_pc_src),
    .WB_reg_write               (WB_reg_write),
    .WB_mem_to_reg              (WB_mem_to_reg),
    .WB_write_back_destination  (WB_write_back_destination),
    .WB_read_data               (WB_read_data),
    .WB_address                 (WB_address)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    MEM_reg_write = 0; MEM_mem_write = 0; MEM_mem_read = 0; MEM_mem_to_reg = 0;
    MEM_branch = 0; MEM_zero = 0; MEM_address = '0; MEM_write_data = '0;
    MEM_write_back_destination = '0; MEM_load_mode = 2'b00;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sw(input logic [31:0] a, input logic [31:0] d);
    idle();
    MEM_mem_write = 1; MEM_address = a; MEM_write_data = d;
    step();
  endtask

  task automatic ld(input logic [1:0] mode, input logic [31:0] a);
    idle();
    MEM_mem_read = 1; MEM_load_mode = mode; MEM_address = a;
    step();
  endtask

  initial begin
    idle();
    rst_n = 0;
    #1;
    chk("rst_rd",   WB_read_data, 32'h0);
    chk("rst_addr", WB_address, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    step();

    // store then loads with each extraction mode
    sw(32'd8, 32'hDEADBEEF);
    ld(LOAD_WORD, 32'd8);
    chk("lw8", WB_read_data, 32'hDEADBEEF);
    chk("lw8_addr", WB_address, 32'd8);
    ld(LOAD_HALF, 32'd10);  chk("lh10", WB_read_data, 32'hFFFFDEAD);
    ld(LOAD_HALF, 32'd8);   chk("lh8",  WB_read_data, 32'hFFFFBEEF);
    ld(LOAD_BYTE, 32'd8);   chk("lb8",  WB_read_data, 32'hFFFFFFEF);
    ld(LOAD_BYTEU, 32'd9);  chk("lbu9", WB_read_data, 32'h000000BE);
    ld(LOAD_BYTE, 32'd11);  chk("lb11", WB_read_data, 32'hFFFFFFDE);
    ld(LOAD_BYTEU, 32'd11); chk("lbu11", WB_read_data, 32'h000000DE);
    ld(LOAD_BYTE, 32'd9);   chk("lb9",  WB_read_data, 32'hFFFFFFBE);

    // positive half / byte stay positive
    sw(32'd16, 32'h7F3A5C21);
    ld(LOAD_HALF, 32'd18);  chk("lh18", WB_read_data, 32'h00007F3A);
    ld(LOAD_BYTE, 32'd16);  chk("lb16", WB_read_data, 32'h00000021);
    ld(LOAD_BYTE, 32'd18);  chk("lb18", WB_read_data, 32'h0000003A);

    // same-cycle read and write: old word first, new word next
    sw(32'd4, 32'h11111111);
    idle();
    MEM_mem_write = 1; MEM_mem_read = 1; MEM_address = 32'd4;
    MEM_write_data = 32'h22222222; MEM_load_mode = LOAD_WORD;
    step();
    chk("raw_old", WB_read_data, 32'h11111111);
    ld(LOAD_WORD, 32'd4);   chk("raw_new", WB_read_data, 32'h22222222);

    // address wrap
    sw(MEM_WORDS * 4 + 12, 32'h12345678);
    ld(LOAD_WORD, 32'd12);  chk("wrap", WB_read_data, 32'h12345678);

    // MemRead=0 gives zero data even at a populated address
    idle();
    MEM_address = 32'd8;
    step();
    chk("noread", WB_read_data, 32'h0);

    // branch resolution is combinational
    idle();
    MEM_branch = 1; MEM_zero = 1; #1;
    chk("br11", {31'b0, IF_pc_src}, 32'd1);
    MEM_zero = 0; #1;
    chk("br10", {31'b0, IF_pc_src}, 32'd0);
    MEM_branch = 0; MEM_zero = 1; #1;
    chk("br01", {31'b0, IF_pc_src}, 32'd0);

    // passthrough of control and address
    idle();
    MEM_reg_write = 1; MEM_mem_to_reg = 0;
    MEM_write_back_destination = 5'b01010; MEM_address = 32'd42;
    step();
    chk("pt_rw",   {31'b0, WB_reg_write}, 32'd1);
    chk("pt_m2r",  {31'b0, WB_mem_to_reg}, 32'd0);
    chk("pt_dst",  {27'b0, WB_write_back_destination}, 32'd10);
    chk("pt_addr", WB_address, 32'd42);
    chk("pt_rd",   WB_read_data, 32'h0);
    idle();
    MEM_mem_to_reg = 1; MEM_write_back_destination = 5'd31; MEM_address = 32'hFFFF0000;
    step();
    chk("pt_m2r1", {31'b0, WB_mem_to_reg}, 32'd1);
    chk("pt_rw0",  {31'b0, WB_reg_write}, 32'd0);
    chk("pt_dst31", {27'b0, WB_write_back_destination}, 32'd31);

    // mid-run reset with nonzero WB state and a store in flight
    sw(32'd20, 32'h00000055);
    idle();
    MEM_reg_write = 1; MEM_mem_to_reg = 1; MEM_mem_read = 1;
    MEM_write_back_destination = 5'd7; MEM_address = 32'd20;
    step();
    chk("pre_rst_rd", WB_read_data, 32'h00000055);
    @(negedge clk);
    idle();
    MEM_branch = 1; MEM_zero = 1;
    MEM_mem_write = 1; MEM_address = 32'd20; MEM_write_data = 32'h00000BAD;
    rst_n = 0;
    #1;
    chk("mrst_rw",  {31'b0, WB_reg_write}, 32'd0);
    chk("mrst_m2r", {31'b0, WB_mem_to_reg}, 32'd0);
    chk("mrst_dst", {27'b0, WB_write_back_destination}, 32'd0);
    chk("mrst_rd",  WB_read_data, 32'h0);
    chk("mrst_addr", WB_address, 32'h0);
    chk("mrst_pcsrc", {31'b0, IF_pc_src}, 32'd0);
    @(posedge clk);
    #1;
    idle();
    rst_n = 1;
    ld(LOAD_WORD, 32'd20);  chk("rst_drop_store", WB_read_data, 32'h00000055);
    ld(LOAD_WORD, 32'd8);   chk("mem_kept", WB_read_data, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
